// File: rtl/tb_tcdm_banked_memory_if.sv
// TCDM request/response channel: request handshake plus read/write-acknowledge response.
interface tb_tcdm_banked_memory_if;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/tb_tcdm_banked_memory.sv
// Banked, word-interleaved TCDM model with per-bank round-robin arbitration, LFSR stall
// injection, fixed read latency, byte-enable writes, range errors and per-port counters.
module tb_tcdm_banked_memory #(
    parameter int unsigned MP              = 2,
    parameter int unsigned NB              = 4,
    parameter int unsigned MEMORY_SIZE     = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned STALL_THRESHOLD = 0,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   enable_i,
    input  logic                   randomize_i,
    tb_tcdm_banked_memory_if.slave tcdm [MP],
    output logic [MP-1:0][31:0]    cnt_rd_o,
    output logic [MP-1:0][31:0]    cnt_wr_o,
    output logic [MP-1:0][31:0]    cnt_stall_o,
    output logic [MP-1:0]          err_o
);
    localparam int unsigned PW = (MP > 1) ? $clog2(MP) : 1;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned AW = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;

    logic [31:0] mem [MEMORY_SIZE];

    logic [MP-1:0]          req, wen, gnt, oor;
    logic [MP-1:0][31:0]    add, wdata, word, rsp_word_p0;
    logic [MP-1:0][3:0]     be;
    logic [MP-1:0][BW-1:0]  bank;
    logic [MP-1:0][AW-1:0]  idx;

    logic [NB-1:0]          bank_vld, bank_gnt, stall;
    logic [NB-1:0][PW-1:0]  winner, rr;
    logic [NB-1:0][15:0]    lfsr;
    logic [31:0]            rnd_state;

    logic [MP-1:0][LATENCY-1:0] vld_pipe;
    logic [31:0]                data_pipe [MP][LATENCY];

    for (genvar p = 0; p < MP; p++) begin : g_port
        assign req[p]   = tcdm[p].req;
        assign wen[p]   = tcdm[p].wen;
        assign add[p]   = tcdm[p].add;
        assign wdata[p] = tcdm[p].data;
        assign be[p]    = tcdm[p].be;
        assign tcdm[p].gnt     = gnt[p];
        assign tcdm[p].r_valid = vld_pipe[p][LATENCY-1];
        assign tcdm[p].r_data  = vld_pipe[p][LATENCY-1] ? data_pipe[p][LATENCY-1] : 32'h0;
    end

    function automatic logic [31:0] scramble(input logic [31:0] seed, input int unsigned i);
        logic [31:0] x;
        x = seed ^ (32'(i) * 32'h9E3779B9);
        x = x ^ (x >> 15);
        x = x * 32'h85EBCA6B;
        return x ^ (x >> 13);
    endfunction

    // Address decode; an address below BASE_ADDR wraps and is flagged separately.
    always_comb begin
        for (int p = 0; p < MP; p++) begin
            word[p] = (add[p] - BASE_ADDR) >> 2;
            oor[p]  = (add[p] < BASE_ADDR) || (word[p] >= 32'(MEMORY_SIZE));
            bank[p] = (NB > 1) ? word[p][BW-1:0] : '0;
            idx[p]  = word[p][AW-1:0];
            rsp_word_p0[p] = !wen[p] ? wdata[p] : (oor[p] ? 32'hDEADBEEF : mem[idx[p]]);
        end
    end

    // Round-robin: first pass finds requesters at or above rr, second pass wraps below it.
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            bank_vld[b] = 1'b0;
            winner[b]   = '0;
            stall[b]    = {1'b0, lfsr[b][7:0]} < 9'(STALL_THRESHOLD);
            for (int p = 0; p < MP; p++) begin
                if (!bank_vld[b] && p >= int'(rr[b]) && req[p] && bank[p] == BW'(b)) begin
                    bank_vld[b] = 1'b1;
                    winner[b]   = PW'(p);
                end
            end
            for (int p = 0; p < MP; p++) begin
                if (!bank_vld[b] && req[p] && bank[p] == BW'(b)) begin
                    bank_vld[b] = 1'b1;
                    winner[b]   = PW'(p);
                end
            end
            bank_gnt[b] = bank_vld[b] && !stall[b] && enable_i && !randomize_i;
        end
        for (int p = 0; p < MP; p++)
            gnt[p] = req[p] && bank_gnt[bank[p]] && (winner[bank[p]] == PW'(p));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr          <= '0;
            vld_pipe    <= '0;
            cnt_rd_o    <= '0;
            cnt_wr_o    <= '0;
            cnt_stall_o <= '0;
            err_o       <= '0;
            rnd_state   <= 32'h1;
            for (int b = 0; b < NB; b++)
                lfsr[b] <= LFSR_SEED ^ 16'(b);
        end else begin
            for (int b = 0; b < NB; b++) begin
                lfsr[b] <= {lfsr[b][14:0], lfsr[b][15] ^ lfsr[b][13] ^ lfsr[b][12] ^ lfsr[b][10]};
                if (bank_gnt[b])
                    rr[b] <= (winner[b] == PW'(MP - 1)) ? '0 : winner[b] + 1'b1;
            end
            for (int p = 0; p < MP; p++) begin
                for (int s = LATENCY - 1; s > 0; s--)
                    vld_pipe[p][s] <= vld_pipe[p][s-1];
                vld_pipe[p][0] <= gnt[p];
                if (clear_i) begin
                    cnt_rd_o[p]    <= '0;
                    cnt_wr_o[p]    <= '0;
                    cnt_stall_o[p] <= '0;
                    err_o[p]       <= 1'b0;
                end else begin
                    if (gnt[p] && wen[p])   cnt_rd_o[p]    <= cnt_rd_o[p] + 32'd1;
                    if (gnt[p] && !wen[p])  cnt_wr_o[p]    <= cnt_wr_o[p] + 32'd1;
                    if (req[p] && !gnt[p])  cnt_stall_o[p] <= cnt_stall_o[p] + 32'd1;
                    if (gnt[p] && oor[p])   err_o[p]       <= 1'b1;
                end
            end
            if (randomize_i)
                rnd_state <= rnd_state + 32'h6D2B79F5;
        end
    end

    // Response data stage: gated by the valid pipe at the output, so it needs no reset.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < MP; p++) begin
            for (int s = LATENCY - 1; s > 0; s--)
                data_pipe[p][s] <= data_pipe[p][s-1];
            data_pipe[p][0] <= rsp_word_p0[p];
        end
    end

    // Storage survives reset; banks never collide on a word, so per-port writes are disjoint.
    always_ff @(posedge clk_i) begin
        if (randomize_i) begin
            for (int i = 0; i < int'(MEMORY_SIZE); i++)
                mem[i] <= scramble(rnd_state, i);
        end else begin
            for (int p = 0; p < MP; p++) begin
                if (gnt[p] && !wen[p] && !oor[p]) begin
                    for (int i = 0; i < 4; i++)
                        if (be[p][i]) mem[idx[p]][8*i +: 8] <= wdata[p][8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_tb_tcdm_banked_memory.sv
// Directed bench: three memory instances (base, LATENCY=3, STALL_THRESHOLD=128) on one clock.
module tb_tb_tcdm_banked_memory;
    logic clk_i = 1'b0;
    logic rst_i, clear_i, enable_i, randomize_i;
    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    tb_tcdm_banked_memory_if a_if [2] ();
    tb_tcdm_banked_memory_if b_if [2] ();
    tb_tcdm_banked_memory_if c_if [2] ();

    logic [1:0]       a_req, a_wen, a_gnt, a_rv, a_err;
    logic [1:0][31:0] a_add, a_data, a_rd, a_cnt_rd, a_cnt_wr, a_cnt_st;
    logic [1:0][3:0]  a_be;
    logic [1:0]       b_req, b_wen, b_gnt, b_rv, b_err;
    logic [1:0][31:0] b_add, b_data, b_rd, b_cnt_rd, b_cnt_wr, b_cnt_st;
    logic [1:0][3:0]  b_be;
    logic [1:0]       c_req, c_wen, c_gnt, c_rv, c_err;
    logic [1:0][31:0] c_add, c_data, c_rd, c_cnt_rd, c_cnt_wr, c_cnt_st;
    logic [1:0][3:0]  c_be;

    for (genvar g = 0; g < 2; g++) begin : g_map
        assign a_if[g].req = a_req[g];  assign a_if[g].wen = a_wen[g];
        assign a_if[g].add = a_add[g];  assign a_if[g].data = a_data[g];
        assign a_if[g].be  = a_be[g];
        assign a_gnt[g] = a_if[g].gnt;  assign a_rv[g] = a_if[g].r_valid;
        assign a_rd[g]  = a_if[g].r_data;
        assign b_if[g].req = b_req[g];  assign b_if[g].wen = b_wen[g];
        assign b_if[g].add = b_add[g];  assign b_if[g].data = b_data[g];
        assign b_if[g].be  = b_be[g];
        assign b_gnt[g] = b_if[g].gnt;  assign b_rv[g] = b_if[g].r_valid;
        assign b_rd[g]  = b_if[g].r_data;
        assign c_if[g].req = c_req[g];  assign c_if[g].wen = c_wen[g];
        assign c_if[g].add = c_add[g];  assign c_if[g].data = c_data[g];
        assign c_if[g].be  = c_be[g];
        assign c_gnt[g] = c_if[g].gnt;  assign c_rv[g] = c_if[g].r_valid;
        assign c_rd[g]  = c_if[g].r_data;
    end

    tb_tcdm_banked_memory #(.MP(2), .NB(4), .MEMORY_SIZE(1024), .BASE_ADDR(32'h0), .LATENCY(1),
                            .STALL_THRESHOLD(0), .LFSR_SEED(16'hACE1)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .enable_i(enable_i),
        .randomize_i(randomize_i), .tcdm(a_if), .cnt_rd_o(a_cnt_rd), .cnt_wr_o(a_cnt_wr),
        .cnt_stall_o(a_cnt_st), .err_o(a_err));

    tb_tcdm_banked_memory #(.MP(2), .NB(4), .MEMORY_SIZE(1024), .BASE_ADDR(32'h0), .LATENCY(3),
                            .STALL_THRESHOLD(0), .LFSR_SEED(16'hACE1)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .enable_i(enable_i),
        .randomize_i(randomize_i), .tcdm(b_if), .cnt_rd_o(b_cnt_rd), .cnt_wr_o(b_cnt_wr),
        .cnt_stall_o(b_cnt_st), .err_o(b_err));

    tb_tcdm_banked_memory #(.MP(2), .NB(4), .MEMORY_SIZE(1024), .BASE_ADDR(32'h0), .LATENCY(1),
                            .STALL_THRESHOLD(128), .LFSR_SEED(16'hACE1)) dut_c (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .enable_i(enable_i),
        .randomize_i(randomize_i), .tcdm(c_if), .cnt_rd_o(c_cnt_rd), .cnt_wr_o(c_cnt_wr),
        .cnt_stall_o(c_cnt_st), .err_o(c_err));

    // Reference stall LFSRs for the STALL_THRESHOLD=128 instance.
    logic [3:0][15:0] lfsr_m;
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < 4; b++) lfsr_m[b] <= 16'hACE1 ^ 16'(b);
        end else begin
            for (int b = 0; b < 4; b++)
                lfsr_m[b] <= {lfsr_m[b][14:0],
                              lfsr_m[b][15] ^ lfsr_m[b][13] ^ lfsr_m[b][12] ^ lfsr_m[b][10]};
        end
    end

    task automatic a_xfer(input int p, input logic wen, input logic [31:0] add, input logic [31:0] data,
                          input logic [3:0] be, input logic [31:0] exp, input string tag);
        @(negedge clk_i);
        a_req[p] = 1'b1; a_wen[p] = wen; a_add[p] = add; a_data[p] = data; a_be[p] = be;
        #1 check({tag, "_gnt"}, 32'(a_gnt[p]), 32'd1);
        @(posedge clk_i); #1;
        a_req[p] = 1'b0;
        check({tag, "_rv"}, 32'(a_rv[p]), 32'd1);
        check({tag, "_rd"}, a_rd[p], exp);
    endtask

    task automatic b_burst(input logic wen, input string tag);
        logic [31:0] exp;
        logic        exp_v;
        @(negedge clk_i);
        for (int t = 0; t < 8; t++) begin
            b_req[0] = (t < 4); b_wen[0] = wen; b_add[0] = 32'(4 * t);
            b_data[0] = 32'hB0B00000 + 32'(t); b_be[0] = 4'hF;
            #1;
            if (t < 4) check({tag, "_gnt"}, 32'(b_gnt[0]), 32'd1);
            @(posedge clk_i); #1;
            exp_v = (t >= 2 && t <= 5);
            exp   = exp_v ? 32'hB0B00000 + 32'(t - 2) : 32'h0;
            check({tag, "_rv"}, 32'(b_rv[0]), 32'(exp_v));
            check({tag, "_rd"}, b_rd[0], exp);
        end
        b_req[0] = 1'b0;
    endtask

    task automatic c_run(output logic [31:0] stalls);
        int   grants, cyc, pred_bad, pred_stall;
        logic pred;
        @(negedge clk_i); rst_i = 1'b1;
        @(negedge clk_i); rst_i = 1'b0;
        grants = 0; cyc = 0; pred_bad = 0; pred_stall = 0;
        c_req[0] = 1'b1; c_wen[0] = 1'b1; c_add[0] = 32'h0;
        while (grants < 1000 && cyc < 20000) begin
            #1;
            pred = lfsr_m[c_add[0][3:2]][7:0] < 8'd128;
            if (c_gnt[0] == pred) pred_bad++;
            if (pred) pred_stall++;
            if (c_gnt[0]) grants++;
            @(posedge clk_i); #1;
            c_add[0] = 32'(4 * (grants % 8));
            cyc++;
        end
        c_req[0] = 1'b0;
        check("c_cnt_rd", c_cnt_rd[0], 32'd1000);
        check("c_cnt_stall", c_cnt_st[0], 32'(pred_stall));
        check("c_gnt_vs_lfsr", 32'(pred_bad), 32'd0);
        stalls = c_cnt_st[0];
    endtask

    initial begin
        logic [31:0] st1, st2;
        rst_i = 1'b1; clear_i = 1'b0; enable_i = 1'b1; randomize_i = 1'b0;
        a_req = '0; a_wen = '1; a_add = '0; a_data = '0; a_be = '1;
        b_req = '0; b_wen = '1; b_add = '0; b_data = '0; b_be = '1;
        c_req = '0; c_wen = '1; c_add = '0; c_data = '0; c_be = '1;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_rv", 32'(a_rv[0]), 32'd0);
        check("rst_rd", a_rd[0], 32'h0);
        check("rst_cnt", a_cnt_rd[0], 32'h0);
        check("rst_err", 32'(a_err), 32'd0);
        @(negedge clk_i); rst_i = 1'b0;

        a_xfer(0, 1'b0, 32'h0, 32'h11223344, 4'hF, 32'h11223344, "wr0");
        a_xfer(0, 1'b1, 32'h0, 32'h0, 4'hF, 32'h11223344, "rd0");
        @(posedge clk_i); #1;
        check("idle_rv", 32'(a_rv[0]), 32'd0);
        check("idle_rd", a_rd[0], 32'h0);
        a_xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 32'h0, "wr_zero");
        a_xfer(0, 1'b0, 32'h0, 32'hFFFFFFFF, 4'b0101, 32'hFFFFFFFF, "wr_be");
        a_xfer(0, 1'b1, 32'h0, 32'h0, 4'hF, 32'h00FF00FF, "rd_be");
        a_xfer(1, 1'b0, 32'h10, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, "wr_p1");

        // Both ports on bank 0; the last grant (port 1) leaves the pointer at port 0.
        @(negedge clk_i);
        a_req = 2'b11; a_wen = 2'b11; a_add[0] = 32'h0; a_add[1] = 32'h10;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("cf_gnt0", 32'(a_gnt[0]), 32'(i % 2 == 0));
            check("cf_gnt1", 32'(a_gnt[1]), 32'(i % 2 == 1));
            @(posedge clk_i); #1;
            check("cf_rd", (i % 2 == 0) ? a_rd[0] : a_rd[1],
                  (i % 2 == 0) ? 32'h00FF00FF : 32'hCAFEF00D);
        end
        a_req = 2'b00;
        check("cnt_rd0", a_cnt_rd[0], 32'd5);
        check("cnt_wr0", a_cnt_wr[0], 32'd3);
        check("cnt_st0", a_cnt_st[0], 32'd3);
        check("cnt_rd1", a_cnt_rd[1], 32'd3);
        check("cnt_wr1", a_cnt_wr[1], 32'd1);
        check("cnt_st1", a_cnt_st[1], 32'd3);

        @(negedge clk_i);
        a_req = 2'b11; a_add[0] = 32'h0; a_add[1] = 32'h14;
        #1;
        check("par_gnt0", 32'(a_gnt[0]), 32'd1);
        check("par_gnt1", 32'(a_gnt[1]), 32'd1);
        @(posedge clk_i); #1;
        a_req = 2'b00;
        check("par_rd0", a_rd[0], 32'h00FF00FF);

        a_xfer(0, 1'b0, 32'h1000, 32'h12345678, 4'hF, 32'h12345678, "oor_wr");
        a_xfer(0, 1'b1, 32'h1000, 32'h0, 4'hF, 32'hDEADBEEF, "oor_rd");
        check("oor_err", 32'(a_err), 32'd1);
        a_xfer(0, 1'b1, 32'h0, 32'h0, 4'hF, 32'h00FF00FF, "oor_nowrite");
        check("oor_err_sticky", 32'(a_err), 32'd1);

        @(negedge clk_i);
        clear_i = 1'b1; a_req[0] = 1'b1; a_wen[0] = 1'b1; a_add[0] = 32'h1000;
        @(posedge clk_i); #1;
        clear_i = 1'b0; a_req[0] = 1'b0;
        check("clr_err", 32'(a_err), 32'd0);
        check("clr_cnt_rd", a_cnt_rd[0], 32'd0);
        check("clr_cnt_st", a_cnt_st[1], 32'd0);

        @(negedge clk_i);
        enable_i = 1'b0; a_req[0] = 1'b1; a_wen[0] = 1'b1; a_add[0] = 32'h0;
        #1 check("dis_gnt", 32'(a_gnt[0]), 32'd0);
        @(posedge clk_i); #1;
        check("dis_rv", 32'(a_rv[0]), 32'd0);
        enable_i = 1'b1;
        #1 check("en_gnt", 32'(a_gnt[0]), 32'd1);
        @(posedge clk_i); #1;
        a_req[0] = 1'b0;
        check("en_rd", a_rd[0], 32'h00FF00FF);

        @(negedge clk_i);
        randomize_i = 1'b1; a_req[0] = 1'b1;
        #1 check("rnd_gnt", 32'(a_gnt[0]), 32'd0);
        @(posedge clk_i); #1;
        randomize_i = 1'b0; a_req[0] = 1'b0;

        b_burst(1'b0, "b_wr");
        b_burst(1'b1, "b_rd");

        @(negedge clk_i);
        a_req[0] = 1'b1; a_wen[0] = 1'b1; a_add[0] = 32'h0;
        repeat (2) @(posedge clk_i);
        #1 check("mb_rv_pre", 32'(a_rv[0]), 32'd1);
        @(negedge clk_i); rst_i = 1'b1;
        #1;
        check("mb_rv_rst", 32'(a_rv[0]), 32'd0);
        check("mb_rd_rst", a_rd[0], 32'h0);
        a_req[0] = 1'b0;
        @(posedge clk_i); #1;
        check("mb_rv_next", 32'(a_rv[0]), 32'd0);
        check("mb_cnt_rst", a_cnt_rd[0], 32'd0);
        @(negedge clk_i); rst_i = 1'b0;

        c_run(st1);
        c_run(st2);
        check("c_stall_repeat", st2, st1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
